// File: rtl/matmul_result_display.sv
// Seven-segment display of the four signed 4-bit results from the 2x2 matrix multiplier.
// It captures the results on res_valid, then shows the elements one at a time.
// The decimal point marks a negative value, and a blank gap follows each element.
// An "E" is shown when the multiplier reports an operand error.
module matmul_result_display #(
    parameter int unsigned DWELL_CYCLES = 10000000,
    parameter int unsigned GAP_CYCLES   = 2000000,
    parameter int unsigned CNT_W        = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        res_valid,
    input  logic [15:0] res_data,
    input  logic        res_err,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  idx,
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StShow = 2'd1,
        StGap  = 2'd2,
        StErr  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL_CYCLES - 1);
    // When there is no gap, this value is never used, because the GAP state cannot be reached.
    localparam logic [CNT_W-1:0] GapLast   =
        (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);
    localparam logic [6:0]       SegE      = 7'h79;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      data_q, data_d;
    logic [1:0]       idx_q, idx_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             busy_q, busy_d;

    logic [3:0]       elem;
    logic [3:0]       mag;

    // Map a magnitude in the range 0..8 to segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_decode(input logic [3:0] m);
        logic [6:0] s;
        case (m)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Next-state logic: a capture takes priority over dwell or gap expiry, and ena=0 freezes everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        idx_d   = idx_q;
        if (ena) begin
            if (res_valid) begin
                cnt_d = '0;
                idx_d = 2'd0;
                if (res_err) begin
                    state_d = StErr;
                end else begin
                    state_d = StShow;
                    data_d  = res_data;
                end
            end else begin
                unique case (state_q)
                    StShow: begin
                        if (cnt_q == DwellLast) begin
                            cnt_d = '0;
                            if (GAP_CYCLES == 0) begin
                                idx_d = idx_q + 2'd1;
                            end else begin
                                state_d = StGap;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    StGap: begin
                        if (cnt_q == GapLast) begin
                            cnt_d   = '0;
                            idx_d   = idx_q + 2'd1;
                            state_d = StShow;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outputs are decoded from the next state, so that they register with a latency of one edge.
    always_comb begin
        elem   = data_d[{idx_d, 2'b00} +: 4];
        mag    = elem[3] ? 4'(~elem + 4'd1) : elem;
        seg_d  = 7'h00;
        dp_d   = 1'b0;
        busy_d = 1'b0;
        unique case (state_d)
            StShow: begin
                seg_d  = seg_decode(mag);
                dp_d   = elem[3];
                busy_d = 1'b1;
            end
            StGap:   busy_d = 1'b1;
            StErr:   seg_d  = SegE;
            default: ;
        endcase
    end

    // Register the state and all outputs, with an asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= '0;
            idx_q   <= 2'd0;
            seg_q   <= 7'h00;
            dp_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            busy_q  <= busy_d;
        end
    end

    assign seg  = seg_q;
    assign dp   = dp_q;
    assign idx  = idx_q;
    assign busy = busy_q;

endmodule
